regfile_read_arbiter: RTL
=========================

Name: regfile_read_arbiter

Overview:
- Shares the single 64-bit register-file read port among NUM_REQ requesters, e.g. fetch/decode operand A, operand B and the debug port.
- Arbitrates round-robin and drives the 5-bit read-register select into the 32x64 read mux.
- Captures the returned 64-bit word and hands it back to the winning requester with a one-hot valid.
- Fully pipelined: one read accepted per cycle.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 5, register select width (32 registers)
DATA_W, 64, register data width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester read request; held high until granted
req_addr  input  NUM_REQ x ADDR_W  per-requester register index
flush  input  1  synchronous; kills all in-flight reads
gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as accepted req
ReadRegister  output  ADDR_W  registered select driven to the read mux
ReadData  input  DATA_W  combinational mux output for ReadRegister
rd_valid  output  NUM_REQ  one-hot, registered; read data ready for that requester
rd_data  output  DATA_W  registered read word

Behaviour:
- Reset (reset=0, asynchronous) clears the following, all effective immediately:
  - ReadRegister=0, rd_valid=0, rd_data=0
  - s1_valid=0, s1_id=0
  - rr_ptr=0
- gnt is combinational and is 0 while reset is asserted.
- Arbitration, cycle t:
  - Search req starting at index rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - gnt = onehot(win) if any req is set and flush=0, else 0.
  - At most one gnt bit is ever set.
- Pointer update: on a grant, rr_ptr <= (win+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Stage 1, edge ending cycle t, on a grant:
  - ReadRegister <= req_addr[win]
  - s1_valid <= 1, s1_id <= win
  - With no grant: s1_valid <= 0 and ReadRegister holds its value, so the mux does not toggle.
- Stage 2, edge ending cycle t+1:
  - rd_data <= ReadData.
  - rd_valid <= onehot(s1_id) if s1_valid, else 0.
- rd_data holds its last value when rd_valid=0.
- Latency: grant in cycle t gives rd_valid and rd_data visible in cycle t+2.
- Throughput: one grant per cycle; back-to-back grants to different requesters pipeline with no bubble.
- Requester contract:
  - A requester deasserts req the cycle after gnt, or keeps it high to issue a new read.
  - A requester holding req continuously wins again only after every other active requester has been served (fairness bound NUM_REQ cycles).
- Register 31: no special case. The index is passed through and the mux/register file defines the value, e.g. zero register.
- flush=1:
  - gnt=0 in that cycle.
  - s1_valid <= 0 and rd_valid <= 0 at the next edge; rr_ptr unchanged.
  - A read granted in the cycle before flush is dropped; no rd_valid for it.
- Mid-operation reset: in-flight reads are lost and no rd_valid is produced after reset deasserts. Requesters re-request.
- Simultaneous request and response: a requester may be granted in the same cycle its previous rd_valid is high. Both are legal and independent.
- An out-of-range req bit is impossible by width. req_addr of non-requesting lanes is ignored.

Decomposition:
- Package regfile_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=64, NUM_REGS=32
  - typedef reg_addr_t (logic [4:0])
  - typedef reg_data_t (logic [63:0])
- One sub-module, rr_arbiter (NUM_REQ): combinational priority pick from req and rr_ptr, returning gnt and win index, plus the rr_ptr register.
- Pipeline registers and capture logic stay in the top.

Test Plan:
- Reset: hold reset=0 with req=4'b1111 -> gnt=0, rd_valid=0, ReadRegister=0. Release, then first cycle gnt=4'b0001.
- Single read: req[2]=1, req_addr[2]=5'd7, mux model returns 64'hDEAD_BEEF_0000_0007 -> gnt=4'b0100 at t, ReadRegister=7 at t+1, rd_valid=4'b0100 with rd_data=64'hDEAD_BEEF_0000_0007 at t+2.
- Round-robin: all four req held high with addresses 1..4 -> grants 0001,0010,0100,1000,0001 on consecutive cycles. rd_valid follows 2 cycles later with the matching data per address; no bubbles.
- Fairness with wrap: rr_ptr=3, req=4'b1001 -> gnt=1000, then 0001, then 1000.
- Flush: grant requester 1 at t, assert flush at t+1 -> no rd_valid at t+2; gnt=0 at t+1; requester 1 re-granted at t+2 if still requesting.
- Async reset mid-flight: grant at t, drop reset mid-cycle t+1 -> rd_valid goes 0 immediately and stays 0 after release; the read is never returned.

Source files
------------

// File: rtl/regfile_pkg.sv
// Register-file geometry shared by the read-port arbiter and its users.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 64;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among NUM_REQ requesters, starting the search at rr_ptr.
// Owns the rotating pointer, which advances past the winner on every grant.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   win
);

  logic [IDX_W-1:0] rr_ptr;
  logic             found;

  // First set req bit at or after rr_ptr, wrapping modulo NUM_REQ
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    gnt   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
    if (found && enable) begin
      gnt = NUM_REQ'(1) << win;
    end
  end

  // Pointer moves to the requester after the winner; holds when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (|gnt) begin
      rr_ptr <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the single register-file read port among NUM_REQ requesters.
// Stage 1 registers the winning select and id; stage 2 captures ReadData
// and returns it with a one-hot valid two cycles after the grant.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = REG_DATA_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic                           flush,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [ADDR_W-1:0]              ReadRegister,
  input  logic [DATA_W-1:0]              ReadData,
  output logic [NUM_REQ-1:0]             rd_valid,
  output logic [DATA_W-1:0]              rd_data
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] win;
  logic             s1_valid;
  logic [IDX_W-1:0] s1_id;

  // Grants are suppressed while in reset and during a flush cycle
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .enable (reset & ~flush),
    .gnt    (gnt),
    .win    (win)
  );

  // Stage 1: latch winner's select; ReadRegister holds when idle so the mux is quiet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadRegister <= '0;
      s1_valid     <= 1'b0;
      s1_id        <= '0;
    end else begin
      s1_valid <= |gnt;
      if (|gnt) begin
        ReadRegister <= req_addr[win];
        s1_id        <= win;
      end
    end
  end

  // Stage 2: capture read word for the stage-1 owner; flush drops it, rd_data holds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= '0;
      if (s1_valid && !flush) begin
        rd_valid <= NUM_REQ'(1) << s1_id;
        rd_data  <= ReadData;
      end
    end
  end

endmodule
